pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
Program counter and branch sequencer: the consumer of the carry/zero/borrow flags published by the flag register.
- Each enabled cycle it either increments the PC or evaluates a branch opcode against the current flags and redirects the PC.
- Includes a small CALL/RET return stack.
- Sits between the instruction decoder (which supplies branch requests) and program memory (which receives pc_out).

Parameters:
ADDR_W, 8, program address width in bits
STACK_DEPTH, 4, number of return-stack entries (power of two, >= 2)

Ports:
clk  in  1  system clock, all state updates on rising edge
pc_rst  in  1  synchronous active-high reset
pc_en  in  1  advance enable; when low all state holds and br_valid is ignored
br_valid  in  1  branch request present this cycle
br_op  in  3  branch opcode (see Behaviour)
br_target  in  ADDR_W  absolute branch/call target
flag_c  in  1  carry flag from flag register
flag_z  in  1  zero flag from flag register
flag_b  in  1  borrow flag from flag register
pc_out  out  ADDR_W  current program counter (registered)
br_taken  out  1  one-cycle pulse: redirect happened on the last enabled edge
flush  out  1  high while in FLUSH state (decoder must discard its fetched word)
stack_err  out  1  sticky: return-stack overflow/underflow occurred

Behaviour:
- Reset (pc_rst high at an edge, overrides everything):
  - pc_out=0, br_taken=0, flush=0, stack_err=0.
  - Stack pointer=0 (empty); state=RUN.
- Opcodes and conditions:
  - 000 JMP: always taken.
  - 001 JC: taken if flag_c.
  - 010 JNC: taken if !flag_c.
  - 011 JZ: taken if flag_z.
  - 100 JNZ: taken if !flag_z.
  - 101 JB: taken if flag_b.
  - 110 CALL: always taken; push pc_out+1.
  - 111 RET: always taken; pop into PC.
- Flags are sampled combinationally in the same cycle as br_valid; no internal flag copy.
- States: RUN, FLUSH, FAULT (encoding lives in the package).
- RUN, pc_en=1:
  - br_valid=0, or condition false: pc_out<=pc_out+1, br_taken<=0, stay in RUN.
  - Taken, non-stack op: pc_out<=br_target, br_taken<=1, go to FLUSH.
  - CALL with stack not full: stack[sp]<=pc_out+1, sp<=sp+1, pc_out<=br_target, br_taken<=1, go to FLUSH.
  - RET with stack not empty: sp<=sp-1, pc_out<=stack[sp-1], br_taken<=1, go to FLUSH.
  - CALL with stack full, or RET with stack empty: no push/pop, pc_out holds, stack_err<=1, go to FAULT.
- FLUSH, pc_en=1:
  - pc_out holds, br_valid ignored, br_taken<=0, go to RUN.
  - Bubble length is exactly one enabled cycle; flush=1 for the whole FLUSH state.
- FAULT:
  - pc_out holds, br_taken=0, flush=0, stack_err=1.
  - All requests ignored; only pc_rst exits.
- pc_en=0 in any state:
  - No change to pc_out, sp, stack contents or state.
  - br_taken<=0, so the pulse never stretches.
- Arithmetic:
  - pc_out+1 is modulo 2^ADDR_W: 0xFF -> 0x00 at default width. This wrap is not an error.
  - CALL at 0xFF pushes 0x00.
- Full means sp==STACK_DEPTH; empty means sp==0. The sp width is clog2(STACK_DEPTH)+1.
- Reset mid-FLUSH or mid-FAULT returns to RUN at PC 0 with the stack emptied.
- Stack contents are not cleared by reset; only sp is.

Decomposition:
- Shared package holds:
  - br_op encodings as named constants: OP_JMP..OP_RET.
  - State enum: RUN/FLUSH/FAULT.
  - A condition-evaluation function (br_op, c, z, b -> taken).
- One natural sub-module: ret_stack.
  - LIFO with push/pop/full/empty and synchronous reset of the pointer.
  - Instantiated once, parameterised by ADDR_W and STACK_DEPTH.

Test Plan:
- Reset, then pc_en=1 for 5 cycles, br_valid=0 -> pc_out 0,1,2,3,4,5; br_taken=0 and flush=0 throughout.
- At pc_out=0x10: JZ with target 0x40, flag_z=0 -> pc_out=0x11, no pulse. Repeat with flag_z=1 -> pc_out=0x40, br_taken=1 for one cycle, flush=1 for one cycle, then pc_out=0x41.
- At pc_out=0x20: CALL 0x80, wait out the bubble, RET -> pc_out 0x80, 0x80 (FLUSH), then 0x21 after RET and its bubble.
- Five nested CALLs with default depth 4 -> fifth CALL sets stack_err=1, pc_out frozen, FAULT held for 10 cycles; pc_rst -> pc_out=0, stack_err=0.
- RET on empty stack right after reset -> stack_err=1, pc_out stays 0.
- Load pc_out=0xFF via JMP 0xFF, then increment -> pc_out=0x00, stack_err=0. pc_en=0 for 3 cycles during FLUSH -> pc_out and flush hold, br_taken low after the first edge.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC/branch sequencer: opcode encodings, sequencer
// states and the branch-condition evaluator.
package pc_branch_unit_pkg;

  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_JC   = 3'b001;
  localparam logic [2:0] OP_JNC  = 3'b010;
  localparam logic [2:0] OP_JZ   = 3'b011;
  localparam logic [2:0] OP_JNZ  = 3'b100;
  localparam logic [2:0] OP_JB   = 3'b101;
  localparam logic [2:0] OP_CALL = 3'b110;
  localparam logic [2:0] OP_RET  = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  // CALL and RET are unconditional; their stack checks happen in the sequencer.
  function automatic logic br_cond(input logic [2:0] op, input logic c,
                                   input logic z, input logic b);
    logic taken;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = c;
      OP_JNC:  taken = !c;
      OP_JZ:   taken = z;
      OP_JNZ:  taken = !z;
      OP_JB:   taken = b;
      default: taken = 1'b1;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_branch_unit_ret_stack.sv
// Return-address LIFO; only the pointer is reset, entry contents persist.
module pc_branch_unit_ret_stack
  import pc_branch_unit_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  top_idx;

  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp[IDX_W-1:0] - IDX_W'(1);
  assign top_data = mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !rst) begin
      mem[sp[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and branch sequencer: increments or redirects the PC from
// decoder branch requests evaluated against the live carry/zero/borrow flags.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              pc_rst,
  input  logic              pc_en,
  input  logic              br_valid,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              flag_c,
  input  logic              flag_z,
  input  logic              flag_b,
  output logic [ADDR_W-1:0] pc_out,
  output logic              br_taken,
  output logic              flush,
  output logic              stack_err
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n, pc_inc, stk_top;
  logic              taken_n, err_n;
  logic              push, pop, stk_full, stk_empty;

  assign pc_inc = pc_out + ADDR_W'(1);
  assign flush  = (state == ST_FLUSH);

  pc_branch_unit_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (pc_rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    state_n = state;
    pc_n    = pc_out;
    taken_n = 1'b0;
    err_n   = stack_err;
    push    = 1'b0;
    pop     = 1'b0;
    if (pc_en) begin
      case (state)
        ST_RUN: begin
          if (br_valid && br_cond(br_op, flag_c, flag_z, flag_b)) begin
            // Stack misuse freezes the PC and parks the sequencer until reset.
            if ((br_op == OP_CALL && stk_full) || (br_op == OP_RET && stk_empty)) begin
              err_n   = 1'b1;
              state_n = ST_FAULT;
            end else begin
              push    = (br_op == OP_CALL);
              pop     = (br_op == OP_RET);
              pc_n    = (br_op == OP_RET) ? stk_top : br_target;
              taken_n = 1'b1;
              state_n = ST_FLUSH;
            end
          end else begin
            pc_n = pc_inc;
          end
        end
        ST_FLUSH: state_n = ST_RUN;
        ST_FAULT: state_n = ST_FAULT;
        default:  state_n = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pc_rst) begin
      state     <= ST_RUN;
      pc_out    <= '0;
      br_taken  <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_n;
      pc_out    <= pc_n;
      br_taken  <= taken_n;
      stack_err <= err_n;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: increment, conditional branches,
// CALL/RET, stack overflow/underflow faults, wrap-around and enable stalls.
module tb_pc_branch_unit;

  logic       clk = 1'b0;
  logic       pc_rst, pc_en, br_valid;
  logic [2:0] br_op;
  logic [7:0] br_target;
  logic       flag_c, flag_z, flag_b;
  logic [7:0] pc_out;
  logic       br_taken, flush, stack_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_branch_unit #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .pc_rst    (pc_rst),
    .pc_en     (pc_en),
    .br_valid  (br_valid),
    .br_op     (br_op),
    .br_target (br_target),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_b    (flag_b),
    .pc_out    (pc_out),
    .br_taken  (br_taken),
    .flush     (flush),
    .stack_err (stack_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic [2:0] op, input logic [7:0] tgt);
    br_valid  = v;
    br_op     = op;
    br_target = tgt;
  endtask

  task automatic st(input string tag, input logic [7:0] pc, input logic tk,
                    input logic fl, input logic er);
    chk8({tag, "_pc"}, pc_out, pc);
    chk1({tag, "_taken"}, br_taken, tk);
    chk1({tag, "_flush"}, flush, fl);
    chk1({tag, "_err"}, stack_err, er);
  endtask

  task automatic do_reset();
    pc_rst = 1'b1;
    tick();
    pc_rst = 1'b0;
  endtask

  initial begin
    pc_rst = 1'b1; pc_en = 1'b0;
    flag_c = 1'b0; flag_z = 1'b0; flag_b = 1'b0;
    req(1'b0, 3'b000, 8'h00);
    tick(); tick();
    pc_rst = 1'b0;
    st("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Plain increment
    pc_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      st("inc", 8'(i), 1'b0, 1'b0, 1'b0);
    end

    // JMP to 0x10, bubble, then JZ not taken / taken
    req(1'b1, 3'b000, 8'h10); tick(); st("jmp10", 8'h10, 1'b1, 1'b1, 1'b0);
    req(1'b1, 3'b000, 8'hAA); tick(); st("jmp10_bub", 8'h10, 1'b0, 1'b0, 1'b0);
    req(1'b1, 3'b011, 8'h40); flag_z = 1'b0; tick(); st("jz_nt", 8'h11, 1'b0, 1'b0, 1'b0);
    flag_z = 1'b1; tick(); st("jz_t", 8'h40, 1'b1, 1'b1, 1'b0);
    req(1'b0, 3'b000, 8'h00); flag_z = 1'b0; tick(); st("jz_bub", 8'h40, 1'b0, 1'b0, 1'b0);
    tick(); st("jz_after", 8'h41, 1'b0, 1'b0, 1'b0);

    // Other conditions
    req(1'b1, 3'b010, 8'h70); flag_c = 1'b1; tick(); st("jnc_nt", 8'h42, 1'b0, 1'b0, 1'b0);
    req(1'b1, 3'b001, 8'h70); tick(); st("jc_t", 8'h70, 1'b1, 1'b1, 1'b0);
    req(1'b0, 3'b000, 8'h00); flag_c = 1'b0; tick();
    req(1'b1, 3'b100, 8'h60); flag_z = 1'b1; tick(); st("jnz_nt", 8'h71, 1'b0, 1'b0, 1'b0);
    req(1'b1, 3'b101, 8'h60); flag_b = 1'b0; tick(); st("jb_nt", 8'h72, 1'b0, 1'b0, 1'b0);
    flag_b = 1'b1; tick(); st("jb_t", 8'h60, 1'b1, 1'b1, 1'b0);
    req(1'b0, 3'b000, 8'h00); flag_b = 1'b0; flag_z = 1'b0; tick();

    // CALL / RET round trip from 0x20
    req(1'b1, 3'b000, 8'h20); tick(); req(1'b0, 3'b000, 8'h00); tick();
    st("at20", 8'h20, 1'b0, 1'b0, 1'b0);
    req(1'b1, 3'b110, 8'h80); tick(); st("call80", 8'h80, 1'b1, 1'b1, 1'b0);
    req(1'b0, 3'b000, 8'h00); tick(); st("call_bub", 8'h80, 1'b0, 1'b0, 1'b0);
    req(1'b1, 3'b111, 8'h00); tick(); st("ret", 8'h21, 1'b1, 1'b1, 1'b0);
    req(1'b0, 3'b000, 8'h00); tick(); st("ret_bub", 8'h21, 1'b0, 1'b0, 1'b0);
    tick(); st("ret_after", 8'h22, 1'b0, 1'b0, 1'b0);

    // Four nested CALLs fill the stack, the fifth overflows
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 3'b110, 8'h30 + 8'(i)); tick();
      req(1'b0, 3'b000, 8'h00); tick();
    end
    st("call4", 8'h33, 1'b0, 1'b0, 1'b0);
    req(1'b1, 3'b110, 8'h90); tick(); st("call5_ovf", 8'h33, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      req(1'b1, 3'(i % 8), 8'hC0); flag_c = 1'b1; flag_z = 1'b1; flag_b = 1'b1;
      tick();
      st("fault_hold", 8'h33, 1'b0, 1'b0, 1'b1);
    end
    req(1'b0, 3'b000, 8'h00); flag_c = 1'b0; flag_z = 1'b0; flag_b = 1'b0;
    do_reset(); st("fault_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    // RET on empty stack right after reset
    req(1'b1, 3'b111, 8'h55); tick(); st("ret_empty", 8'h00, 1'b0, 1'b0, 1'b1);
    req(1'b0, 3'b000, 8'h00); tick(); st("ret_empty_hold", 8'h00, 1'b0, 1'b0, 1'b1);
    do_reset();

    // Wrap at 0xFF is not an error
    req(1'b1, 3'b000, 8'hFF); tick(); req(1'b0, 3'b000, 8'h00); tick();
    st("at_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); st("wrap", 8'h00, 1'b0, 1'b0, 1'b0);

    // CALL at 0xFF pushes 0x00
    req(1'b1, 3'b000, 8'hFF); tick(); req(1'b0, 3'b000, 8'h00); tick();
    req(1'b1, 3'b110, 8'h66); tick(); req(1'b0, 3'b000, 8'h00); tick();
    st("call_ff", 8'h66, 1'b0, 1'b0, 1'b0);
    req(1'b1, 3'b111, 8'h00); tick(); st("ret_wrap", 8'h00, 1'b1, 1'b1, 1'b0);
    req(1'b0, 3'b000, 8'h00); tick();

    // pc_en low during FLUSH holds everything but drops the pulse
    req(1'b1, 3'b000, 8'h50); tick(); st("jmp50", 8'h50, 1'b1, 1'b1, 1'b0);
    pc_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      st("stall", 8'h50, 1'b0, 1'b1, 1'b0);
    end
    pc_en = 1'b1; tick(); st("stall_bub", 8'h50, 1'b0, 1'b0, 1'b0);
    req(1'b0, 3'b000, 8'h00); tick(); st("stall_after", 8'h51, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of FLUSH
    req(1'b1, 3'b000, 8'h77); tick();
    req(1'b0, 3'b000, 8'h00); do_reset(); st("flush_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
